// File: rtl/cve2_fetch_fifo_cfg.sv
// Instruction fetch FIFO: word-aligned storage with zero-latency bypass,
// re-assembling 16/32-bit instructions that may straddle word boundaries.
module cve2_fetch_fifo_cfg #(
    parameter int unsigned NUM_REQS = 2,
    parameter bit          RVC_EN   = 1'b1,
    parameter int unsigned LVL_W    = $clog2(NUM_REQS + 2)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    output logic [NUM_REQS-1:0] busy_o,
    output logic [LVL_W-1:0]    level_o,
    input  logic                in_valid_i,
    input  logic [31:0]         in_addr_i,
    input  logic [31:0]         in_rdata_i,
    input  logic                in_err_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [31:0]         out_addr_o,
    output logic [31:0]         out_rdata_o,
    output logic                out_err_o,
    output logic                out_err_plus2_o,
    output logic                out_compressed_o
);

    localparam int unsigned DEPTH = NUM_REQS + 1;

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] valid_pushed, valid_popped;
    logic [DEPTH-1:0] lowest_free, entry_en;
    logic [DEPTH-1:0] err_q, err_d;
    logic [31:0]      rdata_q [DEPTH];
    logic [31:0]      rdata_d [DEPTH];
    logic [31:1]      pc_q;

    logic [31:0] head_rdata, next_rdata;
    logic        head_err, next_err;
    logic        addr_unaligned, compressed;
    logic [1:0]  low_bits;
    logic        valid_aligned, valid_unaligned;
    logic        handshake, pop;
    logic        unused_addr_bit;

    assign unused_addr_bit = in_addr_i[0];

    // Head/next come from storage when present, otherwise straight from the bus.
    assign head_rdata = valid_q[0] ? rdata_q[0] : in_rdata_i;
    assign head_err   = valid_q[0] ? err_q[0]   : (in_valid_i & in_err_i);
    assign next_rdata = valid_q[1] ? rdata_q[1] : in_rdata_i;
    assign next_err   = valid_q[1] ? err_q[1]   : (valid_q[0] & in_valid_i & in_err_i);

    assign addr_unaligned = RVC_EN & pc_q[1];
    assign low_bits       = addr_unaligned ? head_rdata[17:16] : head_rdata[1:0];
    assign compressed     = RVC_EN & (low_bits != 2'b11) & ~head_err;

    assign valid_aligned   = valid_q[0] | in_valid_i;
    assign valid_unaligned = compressed ? valid_aligned
                                        : (valid_q[1] | (valid_q[0] & in_valid_i));

    always_comb begin
        out_valid_o      = valid_aligned;
        out_rdata_o      = head_rdata;
        out_err_o        = head_err;
        out_err_plus2_o  = 1'b0;
        if (addr_unaligned) begin
            out_valid_o     = valid_unaligned;
            out_rdata_o     = {next_rdata[15:0], head_rdata[31:16]};
            out_err_o       = head_err | (next_err & ~compressed);
            out_err_plus2_o = next_err & ~head_err;
        end
    end

    assign out_compressed_o = compressed;
    assign out_addr_o       = {pc_q[31:2], addr_unaligned, 1'b0};

    assign handshake = out_valid_o & out_ready_i;
    // An aligned compressed instruction leaves the upper half still to be consumed.
    assign pop = handshake & (~RVC_EN | addr_unaligned | ~compressed);

    always_comb begin
        lowest_free[0] = ~valid_q[0];
        for (int i = 1; i < DEPTH; i++) begin
            lowest_free[i] = ~valid_q[i] & valid_q[i-1];
        end
    end

    assign valid_pushed = valid_q | ({DEPTH{in_valid_i}} & lowest_free);
    assign valid_popped = pop ? {1'b0, valid_pushed[DEPTH-1:1]} : valid_pushed;
    assign valid_d      = clear_i ? '0 : valid_popped;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_en[i] = in_valid_i & lowest_free[i] & ~pop;
            rdata_d[i]  = in_rdata_i;
            err_d[i]    = in_err_i;
        end
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                entry_en[i] = valid_pushed[i+1];
                rdata_d[i]  = valid_q[i+1] ? rdata_q[i+1] : in_rdata_i;
                err_d[i]    = valid_q[i+1] ? err_q[i+1]   : in_err_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rdata_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (entry_en[i]) begin
                    rdata_q[i] <= rdata_d[i];
                    err_q[i]   <= err_d[i];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q <= '0;
        end else if (clear_i) begin
            pc_q <= {in_addr_i[31:2], RVC_EN & in_addr_i[1]};
        end else if (handshake) begin
            pc_q <= pc_q + (compressed ? 31'd1 : 31'd2);
        end
    end

    always_comb begin
        level_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            level_o = level_o + LVL_W'(valid_q[i]);
        end
    end

    assign busy_o = valid_q[DEPTH-1 -: NUM_REQS];

    push_when_full_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(in_valid_i & valid_q[DEPTH-1] & ~clear_i & ~pop));
    push_pop_when_full_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(in_valid_i & valid_q[DEPTH-1] & ~clear_i & pop));

endmodule

// File: tb/tb_cve2_fetch_fifo_cfg.sv
// Bench for cve2_fetch_fifo_cfg: word-queue reference model with scoreboard,
// directed spec scenarios and two extra parameterisations.
module tb_cve2_fetch_fifo_cfg;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        clear, in_valid, in_err, out_ready;
    logic [31:0] in_addr, in_rdata;
    logic [1:0]  busy, level;
    logic        out_valid, out_err, out_p2, out_cmp;
    logic [31:0] out_addr, out_rdata;

    cve2_fetch_fifo_cfg u_dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .busy_o(busy), .level_o(level),
        .in_valid_i(in_valid), .in_addr_i(in_addr), .in_rdata_i(in_rdata), .in_err_i(in_err),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_addr_o(out_addr),
        .out_rdata_o(out_rdata), .out_err_o(out_err), .out_err_plus2_o(out_p2),
        .out_compressed_o(out_cmp));

    // NUM_REQS=3 instance
    logic        d3_clear, d3_valid;
    logic [31:0] d3_addr, d3_rdata;
    logic [2:0]  d3_busy, d3_level;
    logic        d3_ov, d3_err, d3_p2, d3_cmp;
    logic [31:0] d3_oaddr, d3_ordata;

    cve2_fetch_fifo_cfg #(.NUM_REQS(3)) u_d3 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(d3_clear), .busy_o(d3_busy), .level_o(d3_level),
        .in_valid_i(d3_valid), .in_addr_i(d3_addr), .in_rdata_i(d3_rdata), .in_err_i(1'b0),
        .out_valid_o(d3_ov), .out_ready_i(1'b0), .out_addr_o(d3_oaddr),
        .out_rdata_o(d3_ordata), .out_err_o(d3_err), .out_err_plus2_o(d3_p2),
        .out_compressed_o(d3_cmp));

    // RVC_EN=0 instance
    logic        nr_clear, nr_valid, nr_ready;
    logic [31:0] nr_addr, nr_rdata;
    logic [1:0]  nr_busy, nr_level;
    logic        nr_ov, nr_err, nr_p2, nr_cmp;
    logic [31:0] nr_oaddr, nr_ordata;

    cve2_fetch_fifo_cfg #(.RVC_EN(1'b0)) u_nr (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(nr_clear), .busy_o(nr_busy), .level_o(nr_level),
        .in_valid_i(nr_valid), .in_addr_i(nr_addr), .in_rdata_i(nr_rdata), .in_err_i(1'b0),
        .out_valid_o(nr_ov), .out_ready_i(nr_ready), .out_addr_o(nr_oaddr),
        .out_rdata_o(nr_ordata), .out_err_o(nr_err), .out_err_plus2_o(nr_p2),
        .out_compressed_o(nr_cmp));

    typedef struct {
        logic [31:0] d;
        logic        e;
    } word_t;

    typedef struct {
        logic        v;
        logic [31:0] a;
        logic [31:0] d;
        logic        c;
        logic        e;
        logic        p2;
        logic [1:0]  lvl;
        logic [1:0]  busy;
    } exp_t;

    word_t       mq[$];
    logic [31:0] mpc;
    exp_t        sbq[$];

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // One clock of stimulus on the main DUT; the model predicts this cycle's outputs.
    task automatic step(input logic clr, input logic [31:0] addr, input logic iv,
                        input logic [31:0] id, input logic ie, input logic rdy);
        word_t avail[$];
        word_t head;
        exp_t  x;
        logic  unal, has_next, ne;
        logic [15:0] lo;
        @(negedge clk);
        clear = clr; in_addr = addr; in_valid = iv; in_rdata = id; in_err = ie; out_ready = rdy;
        x = '{v: 1'b0, a: mpc, d: 32'h0, c: 1'b0, e: 1'b0, p2: 1'b0, lvl: 2'(mq.size()),
              busy: {mq.size() >= 3, mq.size() >= 2}};
        avail = mq;
        if (iv) avail.push_back('{d: id, e: ie});
        unal = mpc[1];
        if (avail.size() > 0) begin
            head     = avail[0];
            lo       = unal ? head.d[31:16] : head.d[15:0];
            x.c      = (lo[1:0] != 2'b11) && !head.e;
            has_next = avail.size() >= 2;
            ne       = has_next ? avail[1].e : 1'b0;
            if (!unal) begin
                x.v = 1'b1; x.d = head.d; x.e = head.e; x.p2 = 1'b0;
            end else begin
                x.v  = x.c || has_next;
                x.d  = {has_next ? avail[1].d[15:0] : 16'h0, head.d[31:16]};
                x.e  = head.e | (ne & !x.c);
                x.p2 = ne & !head.e;
            end
            if (x.v && rdy) begin
                mpc = mpc + (x.c ? 32'd2 : 32'd4);
                if (unal || !x.c) void'(avail.pop_front());
            end
        end
        if (clr) begin
            avail.delete();
            mpc = {addr[31:1], 1'b0};
        end
        mq = avail;
        sbq.push_back(x);
    endtask

    // Monitor: drains expectations once the cycle's inputs have settled.
    initial begin : monitor
        exp_t x;
        logic [31:0] mask;
        forever begin
            @(negedge clk);
            #2;
            while (sbq.size() > 0) begin
                x = sbq.pop_front();
                chk("sb_valid", 32'(out_valid), 32'(x.v));
                chk("sb_addr", out_addr, x.a);
                chk("sb_level", 32'(level), 32'(x.lvl));
                chk("sb_busy", 32'(busy), 32'(x.busy));
                if (x.v) begin
                    mask = x.c ? 32'h0000FFFF : 32'hFFFFFFFF;
                    chk("sb_rdata", out_rdata & mask, x.d & mask);
                    chk("sb_cmp", 32'(out_cmp), 32'(x.c));
                    chk("sb_err", 32'(out_err), 32'(x.e));
                    chk("sb_err_plus2", 32'(out_p2), 32'(x.p2));
                end
            end
        end
    end

    initial begin : stim
        logic clr, iv;
        logic [31:0] a, d;
        rst_n = 1'b0;
        clear = 0; in_addr = 0; in_valid = 0; in_rdata = 0; in_err = 0; out_ready = 0;
        d3_clear = 0; d3_valid = 0; d3_addr = 0; d3_rdata = 0;
        nr_clear = 0; nr_valid = 0; nr_ready = 0; nr_addr = 0; nr_rdata = 0;
        mpc = 0;
        #12;
        chk("rst_level", 32'(level), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_addr", out_addr, 0);
        chk("rst_valid", 32'(out_valid), 0);
        in_valid = 1; in_rdata = 32'h13;
        #1;
        chk("rst_bypass_valid", 32'(out_valid), 1);
        in_valid = 0;
        @(negedge clk);
        rst_n = 1'b1;

        // aligned bypass
        step(1, 32'h100, 0, 0, 0, 0);
        step(0, 0, 1, 32'h13, 0, 1);
        #1;
        chk("byp_valid", 32'(out_valid), 1);
        chk("byp_rdata", out_rdata, 32'h13);
        chk("byp_cmp", 32'(out_cmp), 0);
        chk("byp_level", 32'(level), 0);
        step(0, 0, 0, 0, 0, 0);
        #1;
        chk("byp_next_addr", out_addr, 32'h104);
        chk("byp_level_after", 32'(level), 0);

        // compressed pair
        step(1, 32'h100, 0, 0, 0, 0);
        step(0, 0, 1, 32'h45014501, 0, 1);
        #1;
        chk("pair_addr0", out_addr, 32'h100);
        chk("pair_cmp0", 32'(out_cmp), 1);
        step(0, 0, 0, 0, 0, 1);
        #1;
        chk("pair_addr1", out_addr, 32'h102);
        chk("pair_rdata1", 32'(out_rdata[15:0]), 32'h4501);
        chk("pair_level1", 32'(level), 1);
        step(0, 0, 0, 0, 0, 0);
        #1;
        chk("pair_level_end", 32'(level), 0);

        // unaligned 32-bit waits for the second word
        step(1, 32'h102, 0, 0, 0, 0);
        step(0, 0, 1, 32'h00134501, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        #1;
        chk("unal_wait_valid", 32'(out_valid), 0);
        chk("unal_wait_level", 32'(level), 1);
        step(0, 0, 1, 32'hABCD0000, 0, 1);
        #1;
        chk("unal_valid", 32'(out_valid), 1);
        chk("unal_rdata", out_rdata, 32'h00000013);

        // error lies in the upper half of an unaligned instruction
        step(1, 32'h102, 0, 0, 0, 0);
        step(0, 0, 1, 32'h00130000, 0, 0);
        step(0, 0, 1, 32'h12345678, 1, 0);
        #1;
        chk("split_err", 32'(out_err), 1);
        chk("split_err_plus2", 32'(out_p2), 1);

        // PC wrap
        step(1, 32'hFFFFFFFC, 0, 0, 0, 0);
        step(0, 0, 1, 32'h13, 0, 1);
        step(0, 0, 0, 0, 0, 0);
        #1;
        chk("pc_wrap", out_addr, 0);

        // randomized traffic with a mid-run reset
        for (int n = 0; n < 1500; n++) begin
            if (n == 700) begin
                @(negedge clk);
                rst_n = 1'b0; in_valid = 0; clear = 0;
                mq.delete(); mpc = 0;
                #1;
                chk("midrst_level", 32'(level), 0);
                chk("midrst_valid", 32'(out_valid), 0);
                chk("midrst_addr", out_addr, 0);
                @(negedge clk);
                rst_n = 1'b1;
            end
            clr = ($urandom_range(0, 31) == 0);
            a   = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | $urandom_range(0, 15)) : $urandom;
            iv  = ($urandom_range(0, 2) != 0) && (mq.size() < 3 || clr);
            d   = $urandom;
            step(clr, a, iv, d, ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0));
        end
        step(0, 0, 0, 0, 0, 0);

        // NUM_REQS=3: fill, then clear with a same-cycle push
        @(negedge clk);
        d3_valid = 1; d3_rdata = 32'h13;
        repeat (4) @(negedge clk);
        d3_valid = 0;
        #1;
        chk("d3_full_level", 32'(d3_level), 4);
        chk("d3_full_busy", 32'(d3_busy), 32'h7);
        d3_clear = 1; d3_addr = 32'h200; d3_valid = 1;
        @(negedge clk);
        d3_clear = 0; d3_valid = 0;
        #1;
        chk("d3_clear_level", 32'(d3_level), 0);
        chk("d3_clear_addr", d3_oaddr, 32'h200);

        // RVC_EN=0: halfword PC is forced aligned, always +4
        @(negedge clk);
        nr_clear = 1; nr_addr = 32'h102;
        @(negedge clk);
        nr_clear = 0; nr_valid = 1; nr_rdata = 32'h00004501; nr_ready = 1;
        #1;
        chk("nr_addr", nr_oaddr, 32'h100);
        chk("nr_cmp", 32'(nr_cmp), 0);
        chk("nr_valid", 32'(nr_ov), 1);
        @(negedge clk);
        nr_valid = 0; nr_ready = 0;
        #1;
        chk("nr_next_addr", nr_oaddr, 32'h104);
        chk("nr_level", 32'(nr_level), 0);

        #5;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cve2_fetch_fifo_cfg.md
CVE2_FETCH_FIFO_CFG -- requirements
Module: cve2_fetch_fifo_cfg

Interface
REQ-001 SHALL have parameter NUM_REQS, default 2, giving the maximum outstanding bus requests (legal 1..4); DEPTH = NUM_REQS+1 word entries.
REQ-002 SHALL have parameter RVC_EN, default 1, where 1 enables compressed/half-word-aligned instructions and 0 means 32-bit word-aligned instructions only.
REQ-003 SHALL have parameter LVL_W, default $clog2(DEPTH+1), giving the width of level_o.
REQ-004 SHALL have ports, one per line (name, direction, width, meaning):
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- clear_i  in  1  flush all entries; load new PC
- busy_o  out  NUM_REQS  valid flags of the top NUM_REQS entries
- level_o  out  LVL_W  number of valid entries
- in_valid_i  in  1  fetched word valid
- in_addr_i  in  32  new PC, sampled on clear_i
- in_rdata_i  in  32  fetched word
- in_err_i  in  1  bus error for fetched word
- out_valid_o  out  1  instruction available
- out_ready_i  in  1  consumer accepts
- out_addr_o  out  32  PC of output instruction
- out_rdata_o  out  32  instruction bits
- out_err_o  out  1  instruction has fetch error
- out_err_plus2_o  out  1  error lies in the upper half of an unaligned 32-bit instruction
- out_compressed_o  out  1  output instruction is 16-bit

Function
REQ-005 SHALL store word-aligned entries 0..DEPTH-1, with entry 0 as head; the head word is entry 0 if valid, else in_rdata_i/in_err_i (zero-latency bypass).
REQ-006 SHALL treat the next word as entry 1 if valid, else the incoming word.
REQ-007 For aligned output (out_addr_o[1]=0), SHALL drive rdata = head word, err = head err, err_plus2 = 0, and valid = valid_q[0] | in_valid_i.
REQ-008 For unaligned output, SHALL drive rdata = {next[15:0], head[31:16]}.
REQ-009 SHALL define the compressed flag as: selected low half-word [1:0] != 2'b11 and no head error; it is forced to 0 when RVC_EN=0; out_compressed_o SHALL equal this flag.
REQ-010 An unaligned, non-compressed output SHALL be valid only when valid_q[1], or when valid_q[0] & in_valid_i.
REQ-011 Unaligned out_err_o SHALL be: head err | (next err & ~compressed), where next err counts only if its source is valid.
REQ-012 Unaligned out_err_plus2_o SHALL be: next err & ~head err.
REQ-013 On clear_i, SHALL load the PC from in_addr_i[31:1] next cycle; when RVC_EN=0, bit 1 SHALL be forced to 0 and out_addr_o[1:0] SHALL be 0.
REQ-014 On handshake (out_valid_o & out_ready_i), PC SHALL advance by 2 if compressed, else by 4, with 32-bit wrap (0xFFFFFFFC + 4 = 0).
REQ-015 Pop (shift all entries down one) SHALL occur on handshake unless the output is aligned and compressed; when RVC_EN=0, pop SHALL occur on every handshake.
REQ-016 An incoming word SHALL be written to the lowest free entry.
REQ-017 On simultaneous push and pop, the incoming word SHALL land in the entry vacated by the shift; valid count is unchanged.
REQ-018 An incoming word consumed through the bypass and popped in the same cycle SHALL NOT be stored.
REQ-019 clear_i SHALL invalidate all entries next cycle, including any word arriving in the same cycle, and SHALL take priority over push/pop.
REQ-020 level_o SHALL equal popcount(valid_q); busy_o SHALL equal valid_q[DEPTH-1:DEPTH-NUM_REQS].
REQ-021 in_valid_i while valid_q[DEPTH-1]=1 and clear_i=0 is illegal; the block SHALL carry assertions for push-when-full and for push+pop-when-full.
REQ-022 Data/err flops SHALL be enabled only on write or shift.

Reset
REQ-023 On rst_ni low, SHALL asynchronously clear all valid bits, data, err, and PC to 0.
REQ-024 During and after reset: level_o=0, busy_o=0, out_addr_o=0; out_valid_o SHALL follow only the bypass path (in_valid_i).
REQ-025 Reset mid-operation SHALL discard all entries with no residual output.

Verification
REQ-026 Aligned bypass: clear with addr 0x100, then push 0x00000013 with out_ready=1 in the same cycle -> out_valid=1, rdata=0x00000013, compressed=0, next out_addr=0x104, level_o=0.
REQ-027 Compressed pair: push 0x45014501, ready=1 two cycles -> first at 0x100, then 0x102 (rdata[15:0]=0x4501), one pop total, level_o returns to 0.
REQ-028 Unaligned 32-bit: PC=0x102, entry0=0x00134501, no entry1 -> out_valid=0; push 0xABCD0000 -> out_valid=1, rdata=0x00000013.
REQ-029 Error split: PC=0x102, entry0 upper half=0x0013 with err=0, next word err=1 -> out_err=1, out_err_plus2=1.
REQ-030 Fill/clear: NUM_REQS=3, push 4 words without ready -> level_o=4, busy_o=3'b111; clear with addr 0x200 and same-cycle push -> level_o=0 and PC=0x200 next cycle.
REQ-031 RVC_EN=0: clear with addr 0x102, push 0x00004501 -> out_addr=0x100, compressed=0, PC advances by 4.
